// File: rtl/vend_pkg.sv
// Shared types and constants for the vending transaction sequencer.
// Holds the state encoding, coin encodings, the coin-to-nickel value helper,
// and the externally visible credit width.
package vend_pkg;

  // Width of the credit output; arithmetic is done one bit wider so that a
  // coin added at the ceiling cannot wrap before the ceiling compare.
  localparam int CW = 6;
  localparam int AW = CW + 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CREDIT = 2'd1,
    ST_VEND   = 2'd2,
    ST_CHANGE = 2'd3
  } vend_state_t;

  localparam logic [1:0] COIN_NONE    = 2'b00;
  localparam logic [1:0] COIN_NICKEL  = 2'b01;
  localparam logic [1:0] COIN_DIME    = 2'b10;
  localparam logic [1:0] COIN_QUARTER = 2'b11;

  // Value of a coin in nickels; the invalid encoding is worth 0.
  function automatic logic [AW-1:0] coin_value(input logic [1:0] ct);
    case (ct)
      COIN_NICKEL:  return AW'(1);
      COIN_DIME:    return AW'(2);
      COIN_QUARTER: return AW'(5);
      default:      return '0;
    endcase
  endfunction

endpackage

// File: rtl/vend_timer.sv
// Loadable down-counter with an expire flag.
// Ports: load_i/load_val_i reload the count (load wins over counting);
//        expired_o is high while the count sits at zero (1-cycle decode of the register).
module vend_timer #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         expired_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/vend_ctrl.sv
// Vending transaction sequencer: coin credit, price-checked selection,
// dispenser req/ack handshake, nickel-by-nickel change return.
// Inputs:  coin_valid/coin_type, sel_valid/sel_item, cancel, disp_ack, chg_ack.
// Outputs (all registered, 1-cycle latency): disp_req/disp_item, chg_req, credit,
//          coin_reject, short_pulse, sold, fault pulses, busy (VEND or CHANGE).
module vend_ctrl
  import vend_pkg::*;
#(
  parameter int PRICE0       = 6,
  parameter int PRICE1       = 5,
  parameter int PRICE2       = 8,
  parameter int PRICE3       = 10,
  parameter int MAX_CREDIT   = 40,
  parameter int IDLE_TIMEOUT = 1000,
  parameter int DISP_TIMEOUT = 200
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          coin_valid,
  input  logic [1:0]    coin_type,
  input  logic          sel_valid,
  input  logic [1:0]    sel_item,
  input  logic          cancel,
  input  logic          disp_ack,
  input  logic          chg_ack,
  output logic          disp_req,
  output logic [1:0]    disp_item,
  output logic          chg_req,
  output logic [CW-1:0] credit,
  output logic          coin_reject,
  output logic          short_pulse,
  output logic          sold,
  output logic          fault,
  output logic          busy
);

  localparam int TMAX = (IDLE_TIMEOUT > DISP_TIMEOUT) ? IDLE_TIMEOUT : DISP_TIMEOUT;
  localparam int TW   = $clog2(TMAX + 1);

  function automatic logic [AW-1:0] price_of(input logic [1:0] idx);
    case (idx)
      2'd0:    return AW'(PRICE0);
      2'd1:    return AW'(PRICE1);
      2'd2:    return AW'(PRICE2);
      default: return AW'(PRICE3);
    endcase
  endfunction

  vend_state_t   state_q, state_d;
  logic [CW-1:0] credit_q, credit_d;
  logic [1:0]    item_q, item_d;
  logic          disp_req_q, disp_req_d;
  logic          chg_req_q, chg_req_d;
  logic          rej_q, rej_d;
  logic          short_q, short_d;
  logic          sold_q, sold_d;
  logic          fault_q, fault_d;
  logic          busy_q, busy_d;

  logic          tmr_load, tmr_exp;
  logic [TW-1:0] tmr_val;

  logic [AW-1:0] credit_ext, coin_val, coin_sum, price_sel, price_cur;
  logic          coin_ok, any_strobe;

  assign credit_ext = {1'b0, credit_q};
  assign coin_val   = coin_value(coin_type);
  assign coin_sum   = credit_ext + coin_val;
  assign coin_ok    = (coin_val != '0) && (coin_sum <= AW'(MAX_CREDIT));
  assign price_sel  = price_of(sel_item);
  assign price_cur  = price_of(item_q);
  assign any_strobe = coin_valid | sel_valid | cancel;

  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    item_d   = item_q;
    rej_d    = 1'b0;
    short_d  = 1'b0;
    sold_d   = 1'b0;
    fault_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // cancel has nothing to refund here; a select still beats a coin.
        if (sel_valid) begin
          short_d = 1'b1;
          rej_d   = coin_valid;
        end else if (coin_valid) begin
          if (coin_ok) begin
            credit_d = CW'(coin_sum);
            state_d  = ST_CREDIT;
          end else begin
            rej_d = 1'b1;
          end
        end
      end

      ST_CREDIT: begin
        if (cancel) begin
          rej_d   = coin_valid;
          state_d = (credit_q == '0) ? ST_IDLE : ST_CHANGE;
        end else if (sel_valid) begin
          rej_d = coin_valid;
          if (credit_ext >= price_sel) begin
            credit_d = CW'(credit_ext - price_sel);
            item_d   = sel_item;
            state_d  = ST_VEND;
          end else begin
            short_d = 1'b1;
          end
        end else if (coin_valid) begin
          if (coin_ok) begin
            credit_d = CW'(coin_sum);
          end else begin
            rej_d = 1'b1;
          end
        end else if (tmr_exp) begin
          state_d = (credit_q == '0) ? ST_IDLE : ST_CHANGE;
        end
      end

      ST_VEND: begin
        rej_d = coin_valid;
        if (disp_ack) begin
          sold_d  = 1'b1;
          state_d = (credit_q == '0) ? ST_IDLE : ST_CHANGE;
        end else if (tmr_exp) begin
          // Dispenser never answered: give the customer the price back.
          fault_d  = 1'b1;
          credit_d = CW'(credit_ext + price_cur);
          state_d  = ST_CHANGE;
        end
      end

      ST_CHANGE: begin
        rej_d = coin_valid;
        if (credit_q == '0) begin
          state_d = ST_IDLE;
        end else if (chg_req_q && chg_ack) begin
          credit_d = credit_q - CW'(1);
          if (credit_q == CW'(1)) begin
            state_d = ST_IDLE;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // One timer serves both timeouts: reload on every state change, and on
    // any strobe while waiting in CREDIT so the idle window restarts.
    tmr_load = (state_d != state_q) || ((state_q == ST_CREDIT) && any_strobe);
    tmr_val  = (state_d == ST_VEND) ? TW'(DISP_TIMEOUT - 1) : TW'(IDLE_TIMEOUT - 1);

    disp_req_d = (state_d == ST_VEND);
    chg_req_d  = (state_d == ST_CHANGE) && (credit_d != '0);
    busy_d     = (state_d == ST_VEND) || (state_d == ST_CHANGE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      credit_q   <= '0;
      item_q     <= '0;
      disp_req_q <= 1'b0;
      chg_req_q  <= 1'b0;
      rej_q      <= 1'b0;
      short_q    <= 1'b0;
      sold_q     <= 1'b0;
      fault_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      credit_q   <= credit_d;
      item_q     <= item_d;
      disp_req_q <= disp_req_d;
      chg_req_q  <= chg_req_d;
      rej_q      <= rej_d;
      short_q    <= short_d;
      sold_q     <= sold_d;
      fault_q    <= fault_d;
      busy_q     <= busy_d;
    end
  end

  vend_timer #(.W(TW)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .expired_o  (tmr_exp)
  );

  assign disp_req    = disp_req_q;
  assign disp_item   = item_q;
  assign chg_req     = chg_req_q;
  assign credit      = credit_q;
  assign coin_reject = rej_q;
  assign short_pulse = short_q;
  assign sold        = sold_q;
  assign fault       = fault_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_vend_ctrl.sv
// Bench for vend_ctrl: directed walk-throughs of the vending transactions plus
// randomized traffic, every cycle compared against a transaction-level model
// that tracks credit, "vending" and "refunding" flags and up-counting timers.
module tb_vend_ctrl;
  import vend_pkg::*;

  localparam int IDLE_T = 1000;
  localparam int DISP_T = 200;
  localparam int MAXC   = 40;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       coin_valid = 1'b0;
  logic [1:0] coin_type = 2'b00;
  logic       sel_valid = 1'b0;
  logic [1:0] sel_item = 2'b00;
  logic       cancel = 1'b0;
  logic       disp_ack = 1'b0;
  logic       chg_ack = 1'b0;
  logic       disp_req;
  logic [1:0] disp_item;
  logic       chg_req;
  logic [5:0] credit;
  logic       coin_reject;
  logic       short_pulse;
  logic       sold;
  logic       fault;
  logic       busy;

  vend_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .coin_valid  (coin_valid),
    .coin_type   (coin_type),
    .sel_valid   (sel_valid),
    .sel_item    (sel_item),
    .cancel      (cancel),
    .disp_ack    (disp_ack),
    .chg_ack     (chg_ack),
    .disp_req    (disp_req),
    .disp_item   (disp_item),
    .chg_req     (chg_req),
    .credit      (credit),
    .coin_reject (coin_reject),
    .short_pulse (short_pulse),
    .sold        (sold),
    .fault       (fault),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int m_credit = 0;
  bit m_vend   = 0;
  bit m_refund = 0;
  int m_item   = 0;
  int m_cnt    = 0;
  bit e_rej, e_short, e_sold, e_fault;

  function automatic int price_of(input int i);
    case (i)
      0:       return 6;
      1:       return 5;
      2:       return 8;
      default: return 10;
    endcase
  endfunction

  function automatic int nickels(input logic [1:0] t);
    case (t)
      2'b01:   return 1;
      2'b10:   return 2;
      2'b11:   return 5;
      default: return 0;
    endcase
  endfunction

  task automatic model_step();
    int v;
    e_rej = 0; e_short = 0; e_sold = 0; e_fault = 0;
    if (reset) begin
      m_credit = 0; m_vend = 0; m_refund = 0; m_item = 0; m_cnt = 0;
      return;
    end
    v = nickels(coin_type);
    if (m_vend) begin
      e_rej = coin_valid;
      if (disp_ack) begin
        e_sold = 1; m_vend = 0; m_refund = (m_credit > 0);
      end else if (m_cnt == DISP_T - 1) begin
        e_fault = 1; m_credit += price_of(m_item); m_vend = 0; m_refund = 1;
      end else begin
        m_cnt++;
      end
    end else if (m_refund) begin
      e_rej = coin_valid;
      if (chg_ack && m_credit > 0) m_credit--;
      if (m_credit == 0) m_refund = 0;
    end else if (m_credit == 0) begin
      if (sel_valid) begin
        e_short = 1; e_rej = coin_valid;
      end else if (coin_valid) begin
        if (v > 0 && m_credit + v <= MAXC) begin
          m_credit += v; m_cnt = 0;
        end else begin
          e_rej = 1;
        end
      end
    end else begin
      if (cancel) begin
        e_rej = coin_valid; m_refund = 1;
      end else if (sel_valid) begin
        e_rej = coin_valid;
        if (m_credit >= price_of(int'(sel_item))) begin
          m_credit -= price_of(int'(sel_item));
          m_item = int'(sel_item);
          m_vend = 1;
        end else begin
          e_short = 1;
        end
        m_cnt = 0;
      end else if (coin_valid) begin
        if (v > 0 && m_credit + v <= MAXC) m_credit += v;
        else e_rej = 1;
        m_cnt = 0;
      end else if (m_cnt == IDLE_T - 1) begin
        m_refund = 1;
      end else begin
        m_cnt++;
      end
    end
  endtask

  // One clock: inputs already driven, model advances with the DUT, outputs checked.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk("credit",      int'(credit),      m_credit);
    chk("disp_req",    int'(disp_req),    int'(m_vend));
    if (m_vend) chk("disp_item", int'(disp_item), m_item);
    chk("chg_req",     int'(chg_req),     int'(m_refund && m_credit > 0));
    chk("coin_reject", int'(coin_reject), int'(e_rej));
    chk("short_pulse", int'(short_pulse), int'(e_short));
    chk("sold",        int'(sold),        int'(e_sold));
    chk("fault",       int'(fault),       int'(e_fault));
    chk("busy",        int'(busy),        int'(m_vend || m_refund));
    reset = 0; coin_valid = 0; sel_valid = 0; cancel = 0; disp_ack = 0; chg_ack = 0;
  endtask

  task automatic put_coin(input logic [1:0] t);
    coin_valid = 1; coin_type = t; tick();
  endtask
  task automatic press_sel(input logic [1:0] i);
    sel_valid = 1; sel_item = i; tick();
  endtask
  task automatic press_cancel();
    cancel = 1; tick();
  endtask
  task automatic pulse_dack();
    disp_ack = 1; tick();
  endtask
  task automatic pulse_cack();
    chg_ack = 1; tick();
  endtask
  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask
  task automatic apply_reset(input int n);
    for (int i = 0; i < n; i++) begin
      reset = 1; tick();
    end
  endtask

  initial begin
    // Reset state
    apply_reset(2);
    chk("rst_credit", int'(credit), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_disp_req", int'(disp_req), 0);
    chk("rst_chg_req", int'(chg_req), 0);

    // Quarter + nickel, item 0, ack on the third dispense cycle
    put_coin(COIN_QUARTER);  chk("s1_cr5", int'(credit), 5);
    put_coin(COIN_NICKEL);   chk("s1_cr6", int'(credit), 6);
    press_sel(2'd0);
    chk("s1_req", int'(disp_req), 1);
    chk("s1_cr0", int'(credit), 0);
    chk("s1_item", int'(disp_item), 0);
    wait_cycles(2);
    chk("s1_req_hold", int'(disp_req), 1);
    pulse_dack();
    chk("s1_sold", int'(sold), 1);
    chk("s1_req_off", int'(disp_req), 0);
    chk("s1_busy", int'(busy), 0);
    chk("s1_nochg", int'(chg_req), 0);

    // Two quarters, item 3 takes everything
    put_coin(COIN_QUARTER);
    put_coin(COIN_QUARTER);  chk("s2_cr10", int'(credit), 10);
    press_sel(2'd3);
    chk("s2_cr0", int'(credit), 0);
    chk("s2_item", int'(disp_item), 3);
    pulse_dack();
    chk("s2_sold", int'(sold), 1);
    chk("s2_busy", int'(busy), 0);

    // Quarter + dime, item 1, two nickels change
    put_coin(COIN_QUARTER);
    put_coin(COIN_DIME);     chk("s3_cr7", int'(credit), 7);
    press_sel(2'd1);         chk("s3_cr2", int'(credit), 2);
    pulse_dack();
    chk("s3_chg_req", int'(chg_req), 1);
    chk("s3_busy", int'(busy), 1);
    pulse_cack();            chk("s3_cr1", int'(credit), 1);
    pulse_cack();            chk("s3_cr0", int'(credit), 0);
    chk("s3_chg_off", int'(chg_req), 0);
    chk("s3_idle", int'(busy), 0);

    // Ceiling: 8 quarters, extra nickel rejected, cancel returns 40
    for (int i = 0; i < 8; i++) put_coin(COIN_QUARTER);
    chk("s4_cr40", int'(credit), 40);
    put_coin(COIN_NICKEL);
    chk("s4_reject", int'(coin_reject), 1);
    chk("s4_cr_keep", int'(credit), 40);
    press_cancel();
    chk("s4_chg_req", int'(chg_req), 1);
    for (int i = 0; i < 40; i++) pulse_cack();
    chk("s4_cr0", int'(credit), 0);
    chk("s4_idle", int'(busy), 0);

    // Short credit, then idle timeout refunds
    put_coin(COIN_DIME);
    press_sel(2'd2);
    chk("s5_short", int'(short_pulse), 1);
    chk("s5_cr2", int'(credit), 2);
    wait_cycles(IDLE_T - 1);
    chk("s5_not_yet", int'(busy), 0);
    wait_cycles(1);
    chk("s5_timeout", int'(busy), 1);
    chk("s5_chg_req", int'(chg_req), 1);
    pulse_cack();
    pulse_cack();
    chk("s5_done", int'(busy), 0);

    // Dispenser timeout restores price; coin in VEND rejected; reset in CHANGE
    put_coin(COIN_QUARTER);
    put_coin(COIN_NICKEL);
    press_sel(2'd0);
    put_coin(COIN_QUARTER);
    chk("s6_reject", int'(coin_reject), 1);
    chk("s6_cr0", int'(credit), 0);
    wait_cycles(DISP_T - 2);
    chk("s6_no_fault", int'(fault), 0);
    chk("s6_req_hold", int'(disp_req), 1);
    wait_cycles(1);
    chk("s6_fault", int'(fault), 1);
    chk("s6_cr6", int'(credit), 6);
    chk("s6_chg_req", int'(chg_req), 1);
    pulse_cack();
    pulse_cack();
    pulse_cack();
    chk("s6_cr3", int'(credit), 3);
    apply_reset(1);
    chk("s6_rst_cr", int'(credit), 0);
    chk("s6_rst_chg", int'(chg_req), 0);
    chk("s6_rst_busy", int'(busy), 0);

    // Randomized traffic: busy, slow-dispenser and quiet bursts
    for (int b = 0; b < 40; b++) begin
      int kind;
      int len;
      kind = int'($urandom_range(0, 3));
      len  = (kind == 3) ? IDLE_T + 100 : 300;
      for (int c = 0; c < len; c++) begin
        if (kind != 3) begin
          coin_valid = ($urandom_range(0, 3) == 0);
          coin_type  = 2'($urandom_range(0, 3));
          sel_valid  = ($urandom_range(0, 7) == 0);
          sel_item   = 2'($urandom_range(0, 3));
          cancel     = ($urandom_range(0, 15) == 0);
        end
        if (kind == 2) disp_ack = 0;
        else disp_ack = m_vend ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 40) == 0);
        chg_ack = ($urandom_range(0, 2) == 0);
        reset   = ($urandom_range(0, 999) == 0);
        tick();
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
